// File: rtl/hr_pkg.sv
// Shared types and helpers for the heart-rate window sequencer.
// Holds the controller state encoding, default timing constants and the saturating adder.
package hr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COUNT   = 3'd1,
    SHIFT   = 3'd2,
    SUM     = 3'd3,
    PUBLISH = 3'd4
  } hr_state_e;

  localparam int WINDOW_TICKS_DEF = 5000;
  localparam int DEPTH_DEF        = 3;
  localparam int SCALE_DEF        = 4;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

endpackage

// File: rtl/hr_window_sequencer_history.sv
// DEPTH-deep history of closed-window beat counts with push, indexed read and fill count.
// Newest entry sits at index 0; entries never written read as 0.
module hr_history_shift
  import hr_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 8,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              push,
  input  logic [CNT_W-1:0]  din,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [CNT_W-1:0]  rd_data,
  output logic [FILL_W-1:0] fill
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [CNT_W-1:0] hist [DEPTH];

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      fill <= '0;
    end else if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= din;
      if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = hist[i];
    end
  end

endmodule

// File: rtl/hr_window_sequencer.sv
// Heart-rate window sequencer: times windows, counts beats, sums history with one adder
// and publishes a scaled BPM to the display over a req/ack handshake.
module hr_window_sequencer
  import hr_pkg::*;
#(
  parameter int WINDOW_TICKS = WINDOW_TICKS_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int SCALE        = SCALE_DEF,
  parameter int CNT_W        = 8,
  parameter int BPM_W        = 16
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             enable,
  input  logic             beat,
  input  logic             disp_ack,
  output logic [BPM_W-1:0] bpm,
  output logic             disp_req,
  output logic             bpm_valid,
  output logic             overrun,
  output logic             win_done,
  output logic             busy
);

  localparam int TICK_W = $clog2(WINDOW_TICKS);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int ACC_W  = CNT_W + $clog2(DEPTH) + 1;
  localparam int PROD_W = ACC_W + BPM_W + 32;

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_COUNT   = COUNT;
  localparam logic [2:0] ST_SHIFT   = SHIFT;
  localparam logic [2:0] ST_SUM     = SUM;
  localparam logic [2:0] ST_PUBLISH = PUBLISH;

  localparam logic [31:0]       CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WINDOW_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  function automatic logic [BPM_W-1:0] scale_sat(input logic [ACC_W-1:0] a);
    logic [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(SCALE);
    if (p > PROD_W'({BPM_W{1'b1}})) return {BPM_W{1'b1}};
    return p[BPM_W-1:0];
  endfunction

  logic [2:0]        state;
  logic [TICK_W-1:0] tick;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  beat_sat;
  logic [CNT_W-1:0]  snapshot;
  logic [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  hist_rd;
  logic [FILL_W-1:0] fill;
  logic              close;
  logic              stop;

  // Windows only close from COUNT: the in-flight SHIFT/SUM/PUBLISH span is shorter than a window.
  assign close    = (state == ST_COUNT) && (tick == TICK_LAST);
  assign stop     = (state == ST_COUNT) && !close && !enable;
  assign beat_sat = CNT_W'(sat_add(32'(beat_cnt), 32'(beat), CNT_MAX));
  assign win_done = close;
  assign busy     = (state == ST_SHIFT) || (state == ST_SUM);

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (enable) state <= ST_COUNT;
        ST_COUNT:   if (close) state <= ST_SHIFT;
                    else if (!enable) state <= ST_IDLE;
        ST_SHIFT:   state <= ST_SUM;
        ST_SUM:     if (idx == IDX_LAST) state <= ST_PUBLISH;
        ST_PUBLISH: state <= ST_COUNT;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Beats keep accumulating during SHIFT/SUM/PUBLISH so none are lost between windows.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      tick     <= '0;
      beat_cnt <= '0;
      snapshot <= '0;
    end else if (state == ST_IDLE || stop) begin
      tick     <= '0;
      beat_cnt <= '0;
    end else begin
      tick <= (tick == TICK_LAST) ? '0 : tick + TICK_W'(1);
      if (close) begin
        snapshot <= beat_sat;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_sat;
      end
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
    end else if (state == ST_SHIFT) begin
      acc <= '0;
      idx <= '0;
    end else if (state == ST_SUM) begin
      acc <= acc + ACC_W'(hist_rd);
      idx <= idx + IDX_W'(1);
    end
  end

  // A publish while a request is still unacked replaces the value and flags overrun.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      bpm       <= '0;
      disp_req  <= 1'b0;
      bpm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (state == ST_PUBLISH) begin
      bpm       <= scale_sat(acc);
      disp_req  <= 1'b1;
      bpm_valid <= (fill == FILL_FULL);
      if (disp_req && !disp_ack) overrun <= 1'b1;
    end else if (disp_req && disp_ack) begin
      disp_req <= 1'b0;
    end
  end

  hr_history_shift #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W),
    .FILL_W(FILL_W)
  ) u_hist (
    .sclk   (sclk),
    .rst    (rst),
    .push   (state == ST_SHIFT),
    .din    (snapshot),
    .rd_idx (idx),
    .rd_data(hist_rd),
    .fill   (fill)
  );

endmodule

// File: tb/tb_hr_window_sequencer.sv
// Scoreboard bench for hr_window_sequencer: stimulus queues expected publishes,
// a monitor pops one per window close and checks the published value and its timing.
module tb_hr_window_sequencer;

  localparam int WT    = 20;
  localparam int DEPTH = 3;

  logic        sclk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, beat = 1'b0, disp_ack = 1'b0;
  logic [15:0] bpm;
  logic        disp_req, bpm_valid, overrun, win_done, busy;

  logic        en2 = 1'b0, beat2 = 1'b0;
  logic [15:0] bpm2;
  logic        disp_req2, bpm_valid2, overrun2, win_done2, busy2;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [15:0] bpm;
    logic        valid;
  } exp_t;
  exp_t q[$];

  always #5 sclk = ~sclk;

  hr_window_sequencer #(.WINDOW_TICKS(WT), .DEPTH(DEPTH), .SCALE(4), .CNT_W(8), .BPM_W(16)) dut (
    .sclk(sclk), .rst(rst), .enable(enable), .beat(beat), .disp_ack(disp_ack),
    .bpm(bpm), .disp_req(disp_req), .bpm_valid(bpm_valid), .overrun(overrun),
    .win_done(win_done), .busy(busy)
  );

  // Long-window instance so one window can carry more beats than the counter holds.
  hr_window_sequencer #(.WINDOW_TICKS(320), .DEPTH(DEPTH), .SCALE(4), .CNT_W(8), .BPM_W(16)) dut_sat (
    .sclk(sclk), .rst(rst), .enable(en2), .beat(beat2), .disp_ack(1'b0),
    .bpm(bpm2), .disp_req(disp_req2), .bpm_valid(bpm_valid2), .overrun(overrun2),
    .win_done(win_done2), .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each window close must be followed DEPTH+2 cycles later by the queued publish.
  initial begin : monitor
    exp_t e;
    logic [15:0] prev_bpm;
    logic aborted;
    prev_bpm = '0;
    forever begin
      @(negedge sclk);
      if (!rst && win_done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_close: got a window close expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          aborted = 1'b0;
          repeat (DEPTH + 2) begin
            @(negedge sclk);
            if (rst) aborted = 1'b1;
          end
          if (!aborted) begin
            chk("bpm_before_publish", bpm, prev_bpm);
            @(negedge sclk);
            if (rst) aborted = 1'b1;
          end
          if (aborted) begin
            prev_bpm = '0;
          end else begin
            chk("bpm_published", bpm, e.bpm);
            chk("bpm_valid", bpm_valid, e.valid);
            chk("disp_req_on_publish", disp_req, 1);
            prev_bpm = e.bpm;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic run_window(input logic [19:0] mask, input int ack_t, input logic req_after_ack,
                            input int ovr_t, input logic ovr_exp, input bit push,
                            input int ebpm, input logic evalid, input int len);
    exp_t e;
    if (push) begin
      e.bpm = 16'(ebpm);
      e.valid = evalid;
      q.push_back(e);
    end
    for (int t = 0; t < len; t++) begin
      beat = mask[t];
      disp_ack = (t == ack_t);
      if (t == WT - 2) chk("win_done_early", win_done, 0);
      if (t == WT - 1) chk("win_done_close", win_done, 1);
      if (ack_t >= 0 && t == ack_t + 1) chk("disp_req_after_ack", disp_req, req_after_ack);
      if (t == ovr_t) chk("overrun", overrun, ovr_exp);
      @(posedge sclk); #1;
    end
    beat = 1'b0;
    disp_ack = 1'b0;
  endtask

  initial begin : stimulus
    bit found;
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_bpm", bpm, 0);
    chk("rst_disp_req", disp_req, 0);
    chk("rst_bpm_valid", bpm_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_win_done", win_done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge sclk); #1;
    enable = 1'b1;
    @(posedge sclk); #1;

    // Windows of 5, 6, 7 beats with no ack; second publish overruns the first.
    run_window(20'h002AA, -1, 0, -1, 0, 1, 20, 0, WT);
    run_window(20'h00AAA, -1, 0,  5, 0, 1, 44, 0, WT);
    run_window(20'h02AAA, -1, 0,  5, 1, 1, 72, 1, WT);
    // Beat on the close cycle counts in the closing window; beat right after goes to the next.
    run_window(20'h8000A, -1, 0, -1, 0, 1, 64, 1, WT);
    run_window(20'h00005, -1, 0, -1, 0, 1, 48, 1, WT);

    // Drop enable mid-COUNT; beats at t6/t7 are discarded with the cleared counter.
    for (int t = 0; t < 8; t++) begin
      beat = (t == 6 || t == 7);
      @(posedge sclk); #1;
    end
    beat = 1'b0;
    enable = 1'b0;
    @(posedge sclk); #1;
    repeat (8) @(posedge sclk);
    #1;
    chk("idle_bpm_held", bpm, 48);
    chk("idle_req_held", disp_req, 1);
    chk("idle_valid_held", bpm_valid, 1);
    chk("idle_busy", busy, 0);
    chk("idle_win_done", win_done, 0);
    enable = 1'b1;
    @(posedge sclk); #1;
    run_window(20'h000AA, -1, 0, -1, 0, 1, 36, 1, WT);

    // Reset while summing: that publish never happens.
    run_window(20'h00002, -1, 0, -1, 0, 1, 0, 0, WT);
    @(posedge sclk); #1;
    chk("busy_in_sum", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_sum_bpm", bpm, 0);
    chk("rst_sum_disp_req", disp_req, 0);
    chk("rst_sum_bpm_valid", bpm_valid, 0);
    chk("rst_sum_overrun", overrun, 0);
    chk("rst_sum_win_done", win_done, 0);
    chk("rst_sum_busy", busy, 0);
    enable = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    rst = 1'b0;
    @(posedge sclk); #1;
    enable = 1'b1;
    @(posedge sclk); #1;

    run_window(20'h0002A, -1, 0, -1, 0, 1, 12, 0, WT);
    // Ack three cycles after disp_req rises (rise is at t5).
    run_window(20'h0000A,  8, 0,  9, 0, 1, 20, 0, WT);
    run_window(20'h00002, -1, 0,  5, 0, 1, 24, 1, WT);
    // Ack in the PUBLISH cycle of a pending request: no overrun, request stays up.
    run_window(20'h00000,  4, 1,  5, 0, 0, 0, 0, 8);
    enable = 1'b0;
    @(posedge sclk); #1;

    // 300 beats in one long window saturate the 8-bit snapshot at 255.
    en2 = 1'b1;
    @(posedge sclk); #1;
    for (int t = 0; t < 300; t++) begin
      beat2 = 1'b1;
      @(posedge sclk); #1;
    end
    beat2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (win_done2) begin
        found = 1'b1;
        break;
      end
      @(posedge sclk); #1;
    end
    chk("sat_close_seen", found, 1);
    if (found) begin
      repeat (5) @(posedge sclk);
      #1;
      chk("sat_bpm_before", bpm2, 0);
      @(posedge sclk); #1;
      chk("sat_bpm", bpm2, 1020);
      chk("sat_bpm_valid", bpm_valid2, 0);
      chk("sat_disp_req", disp_req2, 1);
    end
    en2 = 1'b0;

    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge sclk);
    chk("queue_drained", q.size(), 0);
    repeat (2) @(posedge sclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
